// File: rtl/data_demux1_3_pkg.sv
// Shared select encoding and slot state type for the demux and its 3:1 mux partner.
package data_demux_pkg;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_1    = 2'b01;
  localparam logic [1:0] SEL_2    = 2'b10;
  localparam logic [1:0] SEL_3    = 2'b11;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/data_demux1_3_if.sv
// Producer/consumer bus of the 1:3 demux; master is the environment, slave is the demux.
interface data_demux1_3_if #(
  parameter int unsigned data_wl = 16,
  parameter int unsigned cnt_wl  = 8
);

  logic [data_wl-1:0] in_data;
  logic [1:0]         in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [data_wl-1:0] out_1_data;
  logic [data_wl-1:0] out_2_data;
  logic [data_wl-1:0] out_3_data;
  logic               out_1_valid;
  logic               out_2_valid;
  logic               out_3_valid;
  logic               out_1_ready;
  logic               out_2_ready;
  logic               out_3_ready;
  logic [cnt_wl-1:0]  drop_cnt;

  modport master (
    output in_data, in_sel, in_valid, out_1_ready, out_2_ready, out_3_ready,
    input  in_ready, out_1_data, out_2_data, out_3_data,
           out_1_valid, out_2_valid, out_3_valid, drop_cnt
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_1_ready, out_2_ready, out_3_ready,
    output in_ready, out_1_data, out_2_data, out_3_data,
           out_1_valid, out_2_valid, out_3_valid, drop_cnt
  );

endinterface

// File: rtl/data_demux1_3_slot.sv
// Single-entry output register slice; a drain and a load in the same cycle keep it full.
module demux_slot
  import data_demux_pkg::*;
#(
  parameter int unsigned data_wl = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic [data_wl-1:0] i_data,
  input  logic               i_out_ready,
  output logic               o_out_valid,
  output logic [data_wl-1:0] o_out_data,
  output logic               o_free
);

  slot_state_t        r_state;
  slot_state_t        w_next;
  logic [data_wl-1:0] r_data;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= SLOT_EMPTY;
    else        r_state <= w_next;
  end

  // next state: fill on load, empty only on a drain without load
  always_comb begin
    w_next = r_state;
    case (r_state)
      SLOT_EMPTY: if (i_load) w_next = SLOT_FULL;
      SLOT_FULL:  if (i_out_ready && !i_load) w_next = SLOT_EMPTY;
      default:    w_next = SLOT_EMPTY;
    endcase
  end

  // data register holds its last value until the next load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_data <= '0;
    else if (i_load) r_data <= i_data;
  end

  assign o_out_valid = (r_state == SLOT_FULL);
  assign o_out_data  = r_data;
  assign o_free      = (r_state == SLOT_EMPTY) || i_out_ready;

endmodule

// File: rtl/data_demux1_3.sv
// Registered 1:3 demux: select decode, in_ready mux, three output slots, saturating discard count.
module data_demux1_3
  import data_demux_pkg::*;
#(
  parameter int unsigned data_wl = 16,
  parameter int unsigned cnt_wl  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  data_demux1_3_if.slave  bus
);

  logic [2:0]        w_free;
  logic [2:0]        w_load;
  logic              w_in_ready;
  logic              w_accept;
  logic              w_drop;
  logic [cnt_wl-1:0] r_drop_cnt;

  // in_ready depends only on the select and the addressed slot, never on in_valid
  always_comb begin
    w_in_ready = 1'b1;
    case (bus.in_sel)
      SEL_1:   w_in_ready = w_free[0];
      SEL_2:   w_in_ready = w_free[1];
      SEL_3:   w_in_ready = w_free[2];
      default: w_in_ready = 1'b1;
    endcase
  end

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_load   = {w_accept && (bus.in_sel == SEL_3),
                     w_accept && (bus.in_sel == SEL_2),
                     w_accept && (bus.in_sel == SEL_1)};
  assign w_drop   = w_accept && (bus.in_sel == SEL_NONE);

  // discard counter sticks at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_drop_cnt <= '0;
    else if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + cnt_wl'(1);
  end

  demux_slot #(.data_wl(data_wl)) u_slot_1 (
    .clk(clk), .rst_n(rst_n), .i_load(w_load[0]), .i_data(bus.in_data),
    .i_out_ready(bus.out_1_ready), .o_out_valid(bus.out_1_valid),
    .o_out_data(bus.out_1_data), .o_free(w_free[0])
  );

  demux_slot #(.data_wl(data_wl)) u_slot_2 (
    .clk(clk), .rst_n(rst_n), .i_load(w_load[1]), .i_data(bus.in_data),
    .i_out_ready(bus.out_2_ready), .o_out_valid(bus.out_2_valid),
    .o_out_data(bus.out_2_data), .o_free(w_free[1])
  );

  demux_slot #(.data_wl(data_wl)) u_slot_3 (
    .clk(clk), .rst_n(rst_n), .i_load(w_load[2]), .i_data(bus.in_data),
    .i_out_ready(bus.out_3_ready), .o_out_valid(bus.out_3_valid),
    .o_out_data(bus.out_3_data), .o_free(w_free[2])
  );

  assign bus.in_ready = w_in_ready;
  assign bus.drop_cnt = r_drop_cnt;

endmodule
